// File: rtl/axis_tlast_packetizer.sv
// AXI-Stream packetizer: slices a continuous sample stream into packets of
// programmable length, tagging tuser on the first beat and tlast on the last.
module axis_tlast_packetizer #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned DEFAULT_LEN = 1024,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_enable,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  s_ready_q, s_ready_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic                  main_v_q, main_v_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  main_last_q, main_last_d;
  logic                  main_user_q, main_user_d;
  logic                  skid_v_q, skid_v_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic                  skid_user_q, skid_user_d;

  logic [LEN_WIDTH-1:0]  cfg_len;
  logic                  acc, pop, beat_first, beat_last;

  always_comb begin
    cfg_len    = (cfg_pkt_len == '0) ? LEN_WIDTH'(DEFAULT_LEN) : cfg_pkt_len;
    acc        = s_axis_tvalid & s_ready_q;
    pop        = main_v_q & m_axis_tready;
    beat_first = (cnt_q == '0);
    beat_last  = (cnt_q == len_q - LEN_WIDTH'(1));

    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    pkt_cnt_d   = pkt_cnt_q;
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    main_last_d = main_last_q;
    main_user_d = main_user_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    skid_user_d = skid_user_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          len_d   = cfg_len;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (acc) begin
          busy_d = ~beat_last;
          if (beat_last) begin
            cnt_d = '0;
            if (cfg_enable) len_d = cfg_len;
            else            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Drain first so an incoming beat lands in main whenever main frees up.
    if (pop) begin
      if (skid_v_q) begin
        main_data_d = skid_data_q;
        main_last_d = skid_last_q;
        main_user_d = skid_user_q;
        skid_v_d    = 1'b0;
      end else begin
        main_v_d = 1'b0;
      end
      if (main_last_q) pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
    end

    if (acc) begin
      if (!main_v_d) begin
        main_v_d    = 1'b1;
        main_data_d = s_axis_tdata;
        main_last_d = beat_last;
        main_user_d = beat_first;
      end else begin
        skid_v_d    = 1'b1;
        skid_data_d = s_axis_tdata;
        skid_last_d = beat_last;
        skid_user_d = beat_first;
      end
    end

    s_ready_d = ~skid_v_d & (state_d == ST_RUN);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      pkt_cnt_q   <= '0;
      main_v_q    <= 1'b0;
      main_data_q <= '0;
      main_last_q <= 1'b0;
      main_user_q <= 1'b0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      skid_user_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      s_ready_q   <= s_ready_d;
      pkt_cnt_q   <= pkt_cnt_d;
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      main_last_q <= main_last_d;
      main_user_q <= main_user_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      skid_user_q <= skid_user_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = main_v_q;
  assign m_axis_tdata  = main_data_q;
  assign m_axis_tlast  = main_last_q;
  assign m_axis_tuser  = main_user_q;
  assign busy          = busy_q;
  assign pkt_count     = pkt_cnt_q;

endmodule

// File: tb/tb_axis_tlast_packetizer.sv
// Randomized bench for axis_tlast_packetizer: accepted input beats are compared
// against output beats whose tlast/tuser come from a packet-length model.
module tb_axis_tlast_packetizer;

  logic         clk = 1'b0;
  logic         aresetn = 1'b1;
  logic         cfg_enable = 1'b0;
  logic [15:0]  cfg_pkt_len = '0;
  logic [127:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [127:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b0;
  logic         m_tlast;
  logic         m_tuser;
  logic         busy;
  logic [31:0]  pkt_count;

  axis_tlast_packetizer #(
    .DATA_WIDTH (128),
    .LEN_WIDTH  (16),
    .DEFAULT_LEN(1024),
    .CNT_WIDTH  (32)
  ) dut (
    .aclk         (clk),
    .aresetn      (aresetn),
    .cfg_enable   (cfg_enable),
    .cfg_pkt_len  (cfg_pkt_len),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser),
    .busy         (busy),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic         l;
    logic         u;
    int           c;
  } beat_t;

  beat_t in_q[$];
  beat_t out_q[$];
  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    stab_viol = 0;
  int unsigned seq = 0;
  logic         hold_prev = 1'b0;
  logic [127:0] prev_d;
  logic         prev_l, prev_u;

  // Negedge sampling: a handshake seen here completes on the following posedge.
  always @(negedge clk) begin
    cyc++;
    if (s_tvalid && s_tready) in_q.push_back('{s_tdata, 1'b0, 1'b0, cyc});
    if (m_tvalid && m_tready) out_q.push_back('{m_tdata, m_tlast, m_tuser, cyc});
    if (aresetn && hold_prev &&
        (!m_tvalid || m_tdata !== prev_d || m_tlast !== prev_l || m_tuser !== prev_u))
      stab_viol++;
    hold_prev = aresetn && m_tvalid && !m_tready;
    prev_d = m_tdata;
    prev_l = m_tlast;
    prev_u = m_tuser;
  end

  // Reference: walk packet lengths (last entry repeats) over the accepted beats.
  function automatic int build_exp(input int lens[$]);
    int p = 0, pos = 0, lasts = 0, len;
    exp_q.delete();
    foreach (in_q[i]) begin
      len = lens[(p < lens.size()) ? p : lens.size() - 1];
      exp_q.push_back('{in_q[i].d, (pos == len - 1), (pos == 0), in_q[i].c + 1});
      if (pos == len - 1) lasts++;
      pos++;
      if (pos == len) begin
        pos = 0;
        p++;
      end
    end
    return lasts;
  endfunction

  task automatic do_reset(input logic [15:0] len);
    aresetn = 1'b0;
    cfg_enable = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    cfg_pkt_len = len;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    in_q.delete();
    out_q.delete();
  endtask

  task automatic send(input int n, input int vpct, input int rpct, input int hook_at,
                      input logic [15:0] hook_len, input logic hook_en);
    int   issued = 0, sent = 0, lim = 0;
    logic acc_l = 1'b0;
    while (sent < n && lim < 20000) begin
      @(posedge clk); #1;
      if (acc_l) s_tvalid = 1'b0;
      if (acc_l && sent == hook_at + 1) begin
        cfg_pkt_len = hook_len;
        cfg_enable  = hook_en;
      end
      if (!s_tvalid && issued < n && $urandom_range(99) < vpct) begin
        s_tdata  = {$urandom(), $urandom(), $urandom(), seq};
        seq++;
        s_tvalid = 1'b1;
        issued++;
      end
      m_tready = ($urandom_range(99) < rpct);
      @(negedge clk);
      acc_l = s_tvalid && s_tready;
      if (acc_l) sent++;
      lim++;
    end
    @(posedge clk); #1 s_tvalid = 1'b0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL send_timeout accepted=%0d required=%0d", sent, n);
    end
  endtask

  task automatic drain();
    int lim = 0;
    m_tready = 1'b1;
    while (m_tvalid && lim < 200) begin
      @(posedge clk); #1;
      lim++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout m_tvalid=%b required=0", m_tvalid);
    end
  endtask

  task automatic test_reset();
    #2 aresetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_tvalid, s_tready, m_tlast, m_tuser, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b required=00000", {m_tvalid, s_tready, m_tlast, m_tuser, busy});
    end
    checks++;
    if (pkt_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_pkt_count got=%0d required=0", pkt_count);
    end
    checks++;
    if (m_tdata !== '0) begin
      errors++;
      $display("FAIL reset_tdata got=%h required=0", m_tdata);
    end
    do_reset(16'd4);
    repeat (5) @(negedge clk);
    checks++;
    if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got s_tready=%b m_tvalid=%b required 0 0", s_tready, m_tvalid);
    end
  endtask

  task automatic test_basic();
    int lasts;
    do_reset(16'd4);
    cfg_enable = 1'b1;
    send(12, 100, 100, -1, 16'd0, 1'b1);
    drain();
    lasts = build_exp('{4});
    checks++;
    if (out_q.size() != 12 || lasts != 3) begin
      errors++;
      $display("FAIL basic_count got=%0d required=12", out_q.size());
    end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if ({out_q[i].d, out_q[i].l, out_q[i].u, out_q[i].c} !==
          {exp_q[i].d, exp_q[i].l, exp_q[i].u, exp_q[i].c}) begin
        errors++;
        $display("FAIL basic_beat%0d got l=%b u=%b cyc=%0d required l=%b u=%b cyc=%0d",
                 i, out_q[i].l, out_q[i].u, out_q[i].c, exp_q[i].l, exp_q[i].u, exp_q[i].c);
      end
    end
    checks++;
    if (pkt_count !== 32'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pkt_count got=%0d busy=%b required=3 busy=0", pkt_count, busy);
    end
  endtask

  task automatic test_len_edges();
    int lasts, bad;
    do_reset(16'd0);
    cfg_enable = 1'b1;
    send(2048, 100, 100, -1, 16'd0, 1'b1);
    drain();
    lasts = build_exp('{1024});
    bad = 0;
    foreach (exp_q[i])
      if (i >= out_q.size() || {out_q[i].d, out_q[i].l, out_q[i].u} !== {exp_q[i].d, exp_q[i].l, exp_q[i].u})
        bad++;
    checks++;
    if (bad != 0 || out_q.size() != 2048) begin
      errors++;
      $display("FAIL len0_stream got bad_beats=%0d size=%0d required 0 2048", bad, out_q.size());
    end
    checks++;
    if (pkt_count !== 32'(lasts) || lasts != 2) begin
      errors++;
      $display("FAIL len0_pkt_count got=%0d required=2", pkt_count);
    end

    do_reset(16'd1);
    cfg_enable = 1'b1;
    send(8, 70, 60, -1, 16'd0, 1'b1);
    drain();
    void'(build_exp('{1}));
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if ({out_q[i].d, out_q[i].l, out_q[i].u} !== {exp_q[i].d, 2'b11}) begin
        errors++;
        $display("FAIL len1_beat%0d got l=%b u=%b required l=1 u=1", i, out_q[i].l, out_q[i].u);
      end
    end
    checks++;
    if (pkt_count !== 32'd8 || busy !== 1'b0 || out_q.size() != 8) begin
      errors++;
      $display("FAIL len1_pkt_count got=%0d busy=%b required=8 busy=0", pkt_count, busy);
    end
  endtask

  task automatic test_random();
    int lasts, bad;
    do_reset(16'd7);
    stab_viol = 0;
    cfg_enable = 1'b1;
    send(1000, 60, 50, -1, 16'd0, 1'b1);
    drain();
    lasts = build_exp('{7});
    bad = 0;
    foreach (exp_q[i])
      if (i >= out_q.size() || {out_q[i].d, out_q[i].l, out_q[i].u} !== {exp_q[i].d, exp_q[i].l, exp_q[i].u})
        bad++;
    checks++;
    if (bad != 0 || out_q.size() != 1000) begin
      errors++;
      $display("FAIL random_stream got bad_beats=%0d size=%0d required 0 1000", bad, out_q.size());
    end
    checks++;
    if (stab_viol != 0) begin
      errors++;
      $display("FAIL random_stability got violations=%0d required=0", stab_viol);
    end
    checks++;
    if (pkt_count !== 32'(lasts) || busy !== 1'b1) begin
      errors++;
      $display("FAIL random_pkt_count got=%0d busy=%b required=%0d busy=1", pkt_count, busy, lasts);
    end
  endtask

  task automatic test_len_change();
    do_reset(16'd4);
    cfg_enable = 1'b1;
    send(16, 100, 100, 2, 16'd6, 1'b1);
    drain();
    void'(build_exp('{4, 6}));
    checks++;
    if (out_q.size() != 16) begin
      errors++;
      $display("FAIL lenchg_count got=%0d required=16", out_q.size());
    end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if ({out_q[i].d, out_q[i].l, out_q[i].u} !== {exp_q[i].d, exp_q[i].l, exp_q[i].u}) begin
        errors++;
        $display("FAIL lenchg_beat%0d got l=%b u=%b required l=%b u=%b",
                 i, out_q[i].l, out_q[i].u, exp_q[i].l, exp_q[i].u);
      end
    end
  endtask

  task automatic test_disable();
    do_reset(16'd4);
    cfg_enable = 1'b1;
    send(4, 100, 100, 1, 16'd4, 1'b0);
    drain();
    checks++;
    if (s_tready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL disable_idle got s_tready=%b busy=%b required 0 0", s_tready, busy);
    end
    s_tvalid = 1'b1;
    repeat (4) @(posedge clk);
    #1 s_tvalid = 1'b0;
    checks++;
    if (in_q.size() != 4 || out_q.size() != 4) begin
      errors++;
      $display("FAIL disable_accepts got in=%0d out=%0d required 4 4", in_q.size(), out_q.size());
    end
    cfg_enable = 1'b1;
    send(4, 100, 100, -1, 16'd0, 1'b1);
    drain();
    void'(build_exp('{4}));
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if ({out_q[i].d, out_q[i].l, out_q[i].u} !== {exp_q[i].d, exp_q[i].l, exp_q[i].u}) begin
        errors++;
        $display("FAIL disable_beat%0d got l=%b u=%b required l=%b u=%b",
                 i, out_q[i].l, out_q[i].u, exp_q[i].l, exp_q[i].u);
      end
    end
    checks++;
    if (out_q.size() != 8 || pkt_count !== 32'd2) begin
      errors++;
      $display("FAIL disable_resume got out=%0d pkt_count=%0d required 8 2", out_q.size(), pkt_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset(16'd5);
    cfg_enable = 1'b1;
    send(5, 100, 100, -1, 16'd0, 1'b1);
    drain();
    send(2, 100, 0, -1, 16'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b1 || pkt_count !== 32'd1) begin
      errors++;
      $display("FAIL arst_pre got m_tvalid=%b pkt_count=%0d required 1 1", m_tvalid, pkt_count);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || pkt_count !== 32'd0 || s_tready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_clear got m_tvalid=%b pkt_count=%0d s_tready=%b busy=%b required 0 0 0 0",
               m_tvalid, pkt_count, s_tready, busy);
    end
    do_reset(16'd5);
    cfg_enable = 1'b1;
    send(5, 100, 100, -1, 16'd0, 1'b1);
    drain();
    void'(build_exp('{5}));
    checks++;
    if (out_q.size() != 5 || out_q[0].u !== 1'b1) begin
      errors++;
      $display("FAIL arst_sop got size=%0d required=5 with tuser=1 on first beat", out_q.size());
    end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if ({out_q[i].d, out_q[i].l, out_q[i].u} !== {exp_q[i].d, exp_q[i].l, exp_q[i].u}) begin
        errors++;
        $display("FAIL arst_beat%0d got l=%b u=%b required l=%b u=%b",
                 i, out_q[i].l, out_q[i].u, exp_q[i].l, exp_q[i].u);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_edges();
    test_random();
    test_len_change();
    test_disable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
